// File: rtl/cpu_mem_responder.sv
// Unified program/data RAM for the 8-bit CPU bus, with a byte-stream boot loader
// that fills the RAM while holding the CPU in reset.
//   state   | meaning
//   LOAD    | loader writes incoming bytes, CPU held in reset
//   RELEASE | load finished, CPU still in reset for RELEASE_DLY cycles
//   RUN     | CPU owns the bus; terminal until rst_n
module cpu_mem_responder #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int RELEASE_DLY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          Csel,
    input  logic          read_enable,
    input  logic [AW-1:0] ipnext,
    input  logic [DW-1:0] ram_write_data,
    output logic [DW-1:0] ram_dataout,
    input  logic          boot_valid,
    input  logic [DW-1:0] boot_data,
    input  logic          boot_last,
    output logic          boot_ready,
    output logic          cpu_rst_n,
    output logic [AW:0]   load_count,
    output logic [1:0]    mem_state
);

    localparam int RW = $clog2(RELEASE_DLY + 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] dataout_q;
    logic [AW:0]   load_count_q;
    logic [RW-1:0] rel_cnt_q;
    logic          boot_ready_q;
    logic          cpu_rst_n_q;
    logic          beat;
    logic          load_done;
    logic          cpu_rd;
    logic          cpu_wr;

    assign beat      = (state_q == ST_LOAD) && boot_ready_q && boot_valid;
    // The beat that fills the last RAM location ends the load even without boot_last.
    assign load_done = beat && (boot_last || (load_count_q[AW-1:0] == '1));
    assign cpu_rd    = (state_q == ST_RUN) && Csel && read_enable;
    assign cpu_wr    = (state_q == ST_RUN) && Csel && !read_enable;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:    if (load_done) state_d = ST_RELEASE;
            ST_RELEASE: if (rel_cnt_q == RW'(1)) state_d = ST_RUN;
            ST_RUN:     state_d = ST_RUN;
            default:    state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            boot_ready_q <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            load_count_q <= '0;
            rel_cnt_q    <= '0;
            dataout_q    <= '0;
        end else begin
            state_q      <= state_d;
            boot_ready_q <= (state_d == ST_LOAD);
            cpu_rst_n_q  <= (state_d == ST_RUN);
            if (beat)
                load_count_q <= load_count_q + (AW+1)'(1);
            if (state_q == ST_LOAD && state_d == ST_RELEASE)
                rel_cnt_q <= RW'(RELEASE_DLY);
            else if (state_q == ST_RELEASE && rel_cnt_q != '0)
                rel_cnt_q <= rel_cnt_q - RW'(1);
            if (cpu_rd)
                dataout_q <= mem[ipnext];
        end
    end

    // RAM has no reset: contents must survive rst_n so a partial load is visible.
    always_ff @(posedge clk) begin
        if (beat)
            mem[load_count_q[AW-1:0]] <= boot_data;
        else if (cpu_wr)
            mem[ipnext] <= ram_write_data;
    end

    assign ram_dataout = dataout_q;
    assign boot_ready  = boot_ready_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign load_count  = load_count_q;
    assign mem_state   = state_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: boot load, release timing, CPU bus
// vectors, randomized RUN traffic against a RAM model, reset and gap corner cases.
module tb_cpu_mem_responder;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int DLY = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Csel = 1'b0;
    logic          read_enable = 1'b0;
    logic [AW-1:0] ipnext = '0;
    logic [DW-1:0] ram_write_data = '0;
    logic [DW-1:0] ram_dataout;
    logic          boot_valid = 1'b0;
    logic [DW-1:0] boot_data = '0;
    logic          boot_last = 1'b0;
    logic          boot_ready;
    logic          cpu_rst_n;
    logic [AW:0]   load_count;
    logic [1:0]    mem_state;

    cpu_mem_responder #(.AW(AW), .DW(DW), .RELEASE_DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n), .Csel(Csel), .read_enable(read_enable),
        .ipnext(ipnext), .ram_write_data(ram_write_data), .ram_dataout(ram_dataout),
        .boot_valid(boot_valid), .boot_data(boot_data), .boot_last(boot_last),
        .boot_ready(boot_ready), .cpu_rst_n(cpu_rst_n), .load_count(load_count),
        .mem_state(mem_state)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [DW-1:0] m [256];
    logic [DW-1:0] exp_dout = '0;

    typedef struct {
        logic          cs;
        logic          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vec [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; Csel = 1'b0; boot_valid = 1'b0; boot_last = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last);
        boot_valid = 1'b1; boot_data = d; boot_last = last;
        step();
        boot_valid = 1'b0; boot_last = 1'b0;
    endtask

    task automatic wait_run(input string name);
        int k = 0;
        while (mem_state !== 2'b10 && k < 20) begin
            step();
            k++;
        end
        chk(name, {30'd0, mem_state}, 32'h2);
    endtask

    // Drive one bus cycle, update the RAM model, and compare read data.
    task automatic bus_chk(input string name, input logic cs, input logic re,
                           input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (cs && re) exp_dout = m[a];
        if (cs && !re) m[a] = wd;
        Csel = cs; read_enable = re; ipnext = a; ram_write_data = wd;
        step();
        Csel = 1'b0;
        chk(name, {24'd0, ram_dataout}, {24'd0, exp_dout});
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec[0]  = '{1'b1, 1'b1, 8'h00, 8'h00, 8'hA1};
        vec[1]  = '{1'b1, 1'b1, 8'h01, 8'h00, 8'hB2};
        vec[2]  = '{1'b1, 1'b1, 8'h02, 8'h00, 8'hC3};
        vec[3]  = '{1'b1, 1'b0, 8'h80, 8'h5A, 8'hC3};
        vec[4]  = '{1'b1, 1'b1, 8'h80, 8'h00, 8'h5A};
        vec[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h5A};
        vec[6]  = '{1'b0, 1'b0, 8'h01, 8'hFF, 8'h5A};
        vec[7]  = '{1'b1, 1'b0, 8'h81, 8'h33, 8'h5A};
        vec[8]  = '{1'b1, 1'b0, 8'h81, 8'h44, 8'h5A};
        vec[9]  = '{1'b1, 1'b1, 8'h81, 8'h00, 8'h44};
        vec[10] = '{1'b1, 1'b1, 8'h02, 8'h00, 8'hC3};

        // Reset values, during and after reset
        #2;
        chk("rst_ready",   {31'd0, boot_ready}, 32'h0);
        chk("rst_cpu_rst", {31'd0, cpu_rst_n}, 32'h0);
        chk("rst_dout",    {24'd0, ram_dataout}, 32'h0);
        chk("rst_state",   {30'd0, mem_state}, 32'h0);
        chk("rst_count",   {23'd0, load_count}, 32'h0);
        do_reset();
        chk("post_rst_ready", {31'd0, boot_ready}, 32'h1);
        chk("post_rst_state", {30'd0, mem_state}, 32'h0);
        chk("post_rst_cpu",   {31'd0, cpu_rst_n}, 32'h0);

        // Three-byte load and exact release timing
        send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b1);
        m[0] = 8'hA1; m[1] = 8'hB2; m[2] = 8'hC3;
        chk("load3_count", {23'd0, load_count}, 32'd3);
        for (int k = 1; k <= DLY; k++) begin
            chk("release_state", {30'd0, mem_state}, 32'h1);
            chk("release_cpu",   {31'd0, cpu_rst_n}, 32'h0);
            chk("release_ready", {31'd0, boot_ready}, 32'h0);
            step();
        end
        chk("run_state", {30'd0, mem_state}, 32'h2);
        chk("run_cpu",   {31'd0, cpu_rst_n}, 32'h1);

        // Table-driven bus vectors
        for (int i = 0; i < 11; i++) begin
            Csel = vec[i].cs; read_enable = vec[i].re;
            ipnext = vec[i].addr; ram_write_data = vec[i].wd;
            if (vec[i].cs && !vec[i].re) m[vec[i].addr] = vec[i].wd;
            step();
            Csel = 1'b0;
            chk($sformatf("vec%0d", i), {24'd0, ram_dataout}, {24'd0, vec[i].exp});
            exp_dout = vec[i].exp;
        end

        // Randomized RUN traffic against the RAM model; loader inputs must be ignored
        for (int a = 8'h80; a < 8'h90; a++)
            bus_chk("prefill", 1'b1, 1'b0, 8'(a), 8'($urandom));
        for (int i = 0; i < 200; i++) begin
            boot_valid = 1'($urandom_range(0, 1));
            boot_data  = 8'($urandom);
            bus_chk("rand_bus", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    8'(8'h80 + $urandom_range(0, 15)), 8'($urandom));
            chk("rand_ready", {31'd0, boot_ready}, 32'h0);
            chk("rand_count", {23'd0, load_count}, 32'd3);
        end
        boot_valid = 1'b0;

        // Full 256-byte load without boot_last
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("full_count255", {23'd0, load_count}, 32'd255);
                chk("full_state255", {30'd0, mem_state}, 32'h0);
            end
            m[i] = 8'(7 * i + 10);
            send(8'(7 * i + 10), 1'b0);
        end
        chk("full_state", {30'd0, mem_state}, 32'h1);
        chk("full_count", {23'd0, load_count}, 32'd256);
        wait_run("full_run");
        bus_chk("full_rd_ff", 1'b1, 1'b1, 8'hFF, 8'h00);
        chk("full_ff_value", {24'd0, ram_dataout}, 32'h03);
        for (int i = 0; i < 3; i++) begin
            send(8'hEE, 1'b0);
            chk("run_boot_ready", {31'd0, boot_ready}, 32'h0);
            chk("run_boot_count", {23'd0, load_count}, 32'd256);
        end
        bus_chk("full_rd_00", 1'b1, 1'b1, 8'h00, 8'h00);

        // Reset in the middle of a load
        do_reset();
        for (int i = 0; i < 10; i++) begin
            m[i] = 8'(8'h10 + i);
            send(8'(8'h10 + i), 1'b0);
        end
        rst_n = 1'b0;
        #2;
        chk("midrst_cpu",   {31'd0, cpu_rst_n}, 32'h0);
        chk("midrst_count", {23'd0, load_count}, 32'h0);
        chk("midrst_ready", {31'd0, boot_ready}, 32'h0);
        do_reset();
        chk("reload_cpu0", {31'd0, cpu_rst_n}, 32'h0);
        send(8'hE0, 1'b0);
        chk("reload_cpu1", {31'd0, cpu_rst_n}, 32'h0);
        send(8'hE1, 1'b1);
        chk("reload_cpu2", {31'd0, cpu_rst_n}, 32'h0);
        m[0] = 8'hE0; m[1] = 8'hE1;
        wait_run("reload_run");
        for (int i = 0; i < 10; i++)
            bus_chk($sformatf("reload_rd%0d", i), 1'b1, 1'b1, 8'(i), 8'h00);

        // Gaps in boot_valid and boot_last pulsed without valid
        do_reset();
        begin
            int beats = 0;
            for (int i = 0; i < 8; i++) begin
                boot_valid = (i % 2 == 0);
                boot_last  = (i % 2 == 1);
                boot_data  = 8'(8'h60 + i);
                if (i % 2 == 0) begin
                    m[beats] = 8'(8'h60 + i);
                    beats++;
                end
                step();
                chk("gap_count", {23'd0, load_count}, 32'(beats));
                chk("gap_state", {30'd0, mem_state}, 32'h0);
            end
            boot_valid = 1'b0; boot_last = 1'b0;
            m[beats] = 8'h77;
            send(8'h77, 1'b1);
            chk("gap_final_count", {23'd0, load_count}, 32'(beats + 1));
            chk("gap_final_state", {30'd0, mem_state}, 32'h1);
        end
        wait_run("gap_run");
        for (int i = 0; i < 5; i++)
            bus_chk($sformatf("gap_rd%0d", i), 1'b1, 1'b1, 8'(i), 8'h00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
